// File: rtl/cv32e40p_obi_mem_responder.sv
// cv32e40p_obi_mem_responder
// Memory-side responder for an OBI-style req/gnt/rvalid bus. It holds a
// byte-enabled word array and throttles grants by a stall count and an
// outstanding limit. Responses come back in order after RESP_LATENCY cycles.
// It also flags initiator protocol violations.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i / gnt_o        request / combinational grant (accept = req_i && gnt_o)
//   addr_i               byte address, word select = addr_i[MEM_AW+1:2]
//   we_i, be_i, wdata_i  write enable, byte enables, write data
//   rvalid_o, rdata_o    in-order response, rdata_o = 0 unless a read response
//   protocol_err_o       sticky: request withdrawn or changed while waiting
module cv32e40p_obi_mem_responder #(
  parameter int unsigned MEM_AW          = 12,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned GNT_STALL       = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        protocol_err_o
);

  localparam int unsigned DEPTH = 2 ** MEM_AW;
  localparam int unsigned CW    = 3;                 // stall and outstanding counters
  localparam int unsigned SW    = 33;                // one pipeline stage: {valid, rdata}
  localparam int unsigned PW    = SW * RESP_LATENCY;
  localparam int unsigned FW    = 69;                // {addr, we, be, wdata}

  logic                init_q;
  logic [CW-1:0]       stall_q, stall_d;
  logic [CW-1:0]       outst_q, outst_d;
  logic [PW-1:0]       pipe_q, pipe_d;
  logic                pend_q, pend_d;
  logic [FW-1:0]       held_q;
  logic                err_q, err_d;
  logic [31:0]         mem_q [DEPTH];

  logic                accept;
  logic [MEM_AW-1:0]   widx;
  logic [FW-1:0]       fields;

  assign widx   = addr_i[MEM_AW+1:2];
  assign fields = {addr_i, we_i, be_i, wdata_i};

  // Grant uses registered counters only; req_i is the sole input path.
  assign gnt_o  = req_i && init_q && (stall_q == CW'(GNT_STALL))
                  && (outst_q < CW'(MAX_OUTSTANDING));
  assign accept = req_i && gnt_o;

  assign rvalid_o       = pipe_q[PW-1];
  assign rdata_o        = pipe_q[PW-2 -: 32];
  assign protocol_err_o = err_q;

  // Next-state for counters, response pipeline and protocol monitor.
  always_comb begin
    stall_d = stall_q;
    outst_d = outst_q;
    pipe_d  = pipe_q << SW;
    pend_d  = req_i && !gnt_o;
    err_d   = err_q;

    if (!req_i || accept) begin
      stall_d = '0;
    end else if (stall_q != CW'(GNT_STALL)) begin
      stall_d = stall_q + CW'(1);
    end

    if (accept && !rvalid_o) begin
      outst_d = outst_q + CW'(1);
    end else if (!accept && rvalid_o) begin
      outst_d = outst_q - CW'(1);
    end

    // Write responses and idle slots carry zero data.
    pipe_d[SW-1:0] = {accept, (accept && !we_i) ? mem_q[widx] : 32'h0};

    if (pend_q && (!req_i || (fields != held_q))) begin
      err_d = 1'b1;
    end
  end

  // Control state; in-flight responses are dropped on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q  <= 1'b0;
      stall_q <= '0;
      outst_q <= '0;
      pipe_q  <= '0;
      pend_q  <= 1'b0;
      held_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      init_q  <= 1'b1;
      stall_q <= stall_d;
      outst_q <= outst_d;
      pipe_q  <= pipe_d;
      pend_q  <= pend_d;
      held_q  <= fields;
      err_q   <= err_d;
    end
  end

  // Word array, not reset so contents survive a mid-run reset.
  always_ff @(posedge clk_i) begin
    if (accept && we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[widx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Bench for cv32e40p_obi_mem_responder: four configurations run in parallel,
// each driven by random OBI traffic and compared every cycle against a
// transaction-level model (response queue, word array, wait-cycle count).
module tb_cv32e40p_obi_mem_responder;

  localparam int unsigned NINST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NINST; g++) begin : g_inst
    localparam int unsigned AW  = (g == 0) ? 12 : (g == 3) ? 3 : 4;
    localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 4;
    localparam int unsigned MO  = (g == 3) ? 1 : 2;
    localparam int unsigned SG  = (g == 2) ? 3 : (g == 3) ? 2 : 0;
    localparam int unsigned NW  = (AW < 4) ? (1 << AW) : 16;

    logic        rst_n, req, gnt, we, rvalid, perr;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;

    cv32e40p_obi_mem_responder #(
      .MEM_AW(AW), .RESP_LATENCY(LAT), .MAX_OUTSTANDING(MO), .GNT_STALL(SG)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
      .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
      .protocol_err_o(perr)
    );

    // Reference state
    logic [31:0] mem_m [1 << AW];
    resp_t       q[$];
    int          cyc, wait_n;
    bit          init_m, err_m, prev_wait, last_acc, done;
    logic [68:0] prev_f;

    function automatic string tag(input string s);
      return $sformatf("i%0d.%s", g, s);
    endfunction

    function automatic logic [31:0] rnd_addr(input int unsigned idx);
      logic [31:0] a;
      a = $urandom;
      a[AW+1:2] = AW'(idx);
      return a;
    endfunction

    // One bus cycle: check outputs at negedge, advance the model at posedge.
    task automatic step();
      logic        exp_gnt, exp_rv, viol;
      logic [31:0] exp_rd;
      logic [AW-1:0] wi;
      resp_t       r;
      @(negedge clk);
      exp_gnt = req && init_m && (wait_n >= int'(SG)) && (q.size() < int'(MO));
      exp_rv  = (q.size() > 0) && (q[0].due == cyc);
      exp_rd  = exp_rv ? q[0].data : 32'h0;
      chk(tag("gnt"),    32'(gnt),    32'(exp_gnt));
      chk(tag("rvalid"), 32'(rvalid), 32'(exp_rv));
      chk(tag("rdata"),  rdata,       exp_rd);
      chk(tag("perr"),   32'(perr),   32'(err_m));
      viol = prev_wait && (!req || ({addr, we, be, wdata} != prev_f));
      @(posedge clk);
      last_acc = req && exp_gnt;
      if (exp_rv) void'(q.pop_front());
      if (last_acc) begin
        wi = addr[AW+1:2];
        r.due = cyc + int'(LAT);
        r.data = 32'h0;
        if (we) begin
          for (int k = 0; k < 4; k++)
            if (be[k]) mem_m[wi][8*k +: 8] = wdata[8*k +: 8];
        end else begin
          r.data = mem_m[wi];
        end
        q.push_back(r);
      end
      prev_wait = rst_n && req && !exp_gnt;
      wait_n    = prev_wait ? wait_n + 1 : 0;
      prev_f    = {addr, we, be, wdata};
      err_m     = rst_n && (err_m || viol);
      init_m    = rst_n;
      cyc++;
      #1;
    endtask

    task automatic idle(input int unsigned n);
      req = 1'b0;
      repeat (n) begin
        addr  = $urandom;
        wdata = $urandom;
        step();
      end
    endtask

    // Keep the current request up until it is accepted (bounded).
    task automatic hold();
      int n;
      n = 0;
      do begin
        step();
        n++;
      end while (!last_acc && n < 64);
      chk(tag("granted"), 32'(last_acc), 32'h1);
      req = 1'b0;
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d);
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      hold();
    endtask

    task automatic do_reset();
      rst_n = 1'b0;
      req   = 1'b0;
      #1;
      chk(tag("rst_rvalid"), 32'(rvalid), 32'h0);
      chk(tag("rst_rdata"),  rdata,       32'h0);
      chk(tag("rst_perr"),   32'(perr),   32'h0);
      chk(tag("rst_gnt"),    32'(gnt),    32'h0);
      q.delete();
      wait_n = 0; prev_wait = 0; err_m = 0; init_m = 0;
      step();
      step();
      rst_n = 1'b1;
    endtask

    initial begin
      rst_n = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
      cyc = 0; wait_n = 0; init_m = 0; err_m = 0; prev_wait = 0;
      last_acc = 0; done = 0; prev_f = '0;
      #1;
      do_reset();

      // Fill the words used by random traffic.
      for (int i = 0; i < int'(NW); i++) xact(1'b1, rnd_addr(i), 4'hF, $urandom);
      idle(LAT + 1);

      // Full-word write/read, then a partial byte-enable merge.
      xact(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
      xact(1'b0, 32'h100, 4'h0, 32'h0);
      xact(1'b1, 32'h200, 4'hF, 32'h0);
      xact(1'b1, 32'h200, 4'b0101, 32'hAABBCCDD);
      xact(1'b0, 32'h200, 4'h0, 32'h0);
      xact(1'b1, 32'h200, 4'h0, 32'h11111111);
      xact(1'b0, 32'h200, 4'h0, 32'h0);
      idle(LAT + 1);

      // Random compliant traffic, mostly back-to-back.
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        xact(1'($urandom_range(0, 1)), rnd_addr($urandom_range(0, NW - 1)),
             4'($urandom), $urandom);
      end

      // Reset with responses in flight; the earlier write must survive.
      xact(1'b1, rnd_addr(2), 4'hF, 32'h12345678);
      xact(1'b0, rnd_addr(2), 4'h0, 32'h0);
      xact(1'b0, rnd_addr(3), 4'h0, 32'h0);
      do_reset();
      xact(1'b0, rnd_addr(2), 4'h0, 32'h0);
      idle(LAT + 1);

      // Address change while waiting for a grant.
      req = 1'b1; we = 1'b0; be = 4'h0; wdata = 32'h0; addr = rnd_addr(1);
      step();
      addr = addr ^ 32'h4;
      hold();
      idle(LAT + 2);
      do_reset();

      // Request withdrawn before a grant.
      req = 1'b1; we = 1'b0; be = 4'h0; wdata = 32'h0; addr = rnd_addr(1);
      step();
      idle(LAT + 2);
      do_reset();
      idle(LAT + 2);
      done = 1'b1;
    end
  end

  initial begin
    wait (g_inst[0].done && g_inst[1].done && g_inst[2].done && g_inst[3].done);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, %0d of %0d bad so far", n_bad, n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
